moore_seq_detector: RTL

//  Parametrised Moore serial pattern detector: matches a runtime-loadable N-bit pattern on a

---
 rtl/moore_seq_detector_if.sv | 27 ++
 rtl/moore_seq_detector.sv | 84 ++++++++
 2 files changed

// File: rtl/moore_seq_detector_if.sv
// Serial-bit stream, pattern control and detector status bundled for the Moore pattern detector.
interface moore_seq_detector_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 8
);
   localparam int unsigned SW = $clog2(N + 1);

   logic             in_valid;
   logic             in;
   logic             overlap;
   logic             pat_load;
   logic [N-1:0]     pat_in;
   logic             cnt_clr;
   logic             match;
   logic [SW-1:0]    state;
   logic [CNT_W-1:0] match_cnt;

   modport master (
      output in_valid, in, overlap, pat_load, pat_in, cnt_clr,
      input  match, state, match_cnt
   );

   modport slave (
      input  in_valid, in, overlap, pat_load, pat_in, cnt_clr,
      output match, state, match_cnt
   );
endinterface

// File: rtl/moore_seq_detector.sv
// Moore serial detector for a runtime-loadable N-bit pattern; state is the matched-prefix length,
// match decodes state == N and match_cnt counts entries into state N with saturation.
module moore_seq_detector #(
   parameter int unsigned   N        = 4,
   parameter logic [N-1:0]  PAT_INIT = N'(4'b1011),
   parameter int unsigned   CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   moore_seq_detector_if.slave  bus
);
   localparam int unsigned SW = $clog2(N + 1);

   logic [N-1:0]     pat_q,   pat_d;
   logic [SW-1:0]    state_q, state_d;
   logic             match_q, match_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic [SW-1:0]    base;
   logic [SW-1:0]    adv;
   logic [N:0]       cand;
   logic [N:0]       mask;
   logic [N:0]       pfx;

   // Next prefix length for an accepted bit: longest prefix that is a suffix of (prefix(base), in).
   // A completed match in non-overlapping mode discards history, so the candidate is just the new bit.
   always_comb begin
      base = (state_q == SW'(N) && !bus.overlap) ? '0 : state_q;
      cand = (N+1)'({1'b0, pat_q >> (N - 32'(base))} << 1) | (N+1)'(bus.in);
      mask = '0;
      pfx  = '0;
      adv  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         mask = {(N+1){1'b1}} >> (N + 1 - k);
         pfx  = (N+1)'(pat_q >> (N - k));
         if (k <= 32'(base) + 32'd1 && (cand & mask) == pfx) begin
            adv = SW'(k);
         end
      end
   end

   // Next-state / output logic; pattern load outranks bit acceptance and counter clear.
   always_comb begin
      pat_d   = pat_q;
      state_d = state_q;
      match_d = match_q;
      cnt_d   = cnt_q;
      if (bus.pat_load) begin
         pat_d   = bus.pat_in;
         state_d = '0;
         match_d = 1'b0;
         cnt_d   = '0;
      end else begin
         if (bus.in_valid) begin
            state_d = adv;
            match_d = (adv == SW'(N));
            if (adv == SW'(N) && cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         if (bus.cnt_clr) begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q   <= PAT_INIT;
         state_q <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         state_q <= state_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = cnt_q;
endmodule
